// File: rtl/iob_wishbone_arbiter_if.sv
// Bus bundle for the two-master Wishbone to single-slave IOb arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding
// logic: the two Wishbone masters and the IOb memory.
interface iob_wishbone_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // Wishbone master 0
  logic [ADDR_W-1:0] m0_wb_addr_i;
  logic [STRB_W-1:0] m0_wb_select_i;
  logic              m0_wb_we_i;
  logic              m0_wb_cyc_i;
  logic              m0_wb_stb_i;
  logic [DATA_W-1:0] m0_wb_data_i;
  logic              m0_wb_ack_o;
  logic              m0_wb_error_o;
  logic [DATA_W-1:0] m0_wb_data_o;

  // Wishbone master 1
  logic [ADDR_W-1:0] m1_wb_addr_i;
  logic [STRB_W-1:0] m1_wb_select_i;
  logic              m1_wb_we_i;
  logic              m1_wb_cyc_i;
  logic              m1_wb_stb_i;
  logic [DATA_W-1:0] m1_wb_data_i;
  logic              m1_wb_ack_o;
  logic              m1_wb_error_o;
  logic [DATA_W-1:0] m1_wb_data_o;

  // IOb slave port
  logic              valid_o;
  logic [ADDR_W-1:0] address_o;
  logic [DATA_W-1:0] wdata_o;
  logic [STRB_W-1:0] wstrb_o;
  logic [DATA_W-1:0] rdata_i;
  logic              ready_i;
  logic              busy_o;

  modport slave (
    input  m0_wb_addr_i, m0_wb_select_i, m0_wb_we_i, m0_wb_cyc_i, m0_wb_stb_i, m0_wb_data_i,
    output m0_wb_ack_o, m0_wb_error_o, m0_wb_data_o,
    input  m1_wb_addr_i, m1_wb_select_i, m1_wb_we_i, m1_wb_cyc_i, m1_wb_stb_i, m1_wb_data_i,
    output m1_wb_ack_o, m1_wb_error_o, m1_wb_data_o,
    output valid_o, address_o, wdata_o, wstrb_o, busy_o,
    input  rdata_i, ready_i
  );

  modport master (
    output m0_wb_addr_i, m0_wb_select_i, m0_wb_we_i, m0_wb_cyc_i, m0_wb_stb_i, m0_wb_data_i,
    input  m0_wb_ack_o, m0_wb_error_o, m0_wb_data_o,
    output m1_wb_addr_i, m1_wb_select_i, m1_wb_we_i, m1_wb_cyc_i, m1_wb_stb_i, m1_wb_data_i,
    input  m1_wb_ack_o, m1_wb_error_o, m1_wb_data_o,
    input  valid_o, address_o, wdata_o, wstrb_o, busy_o,
    output rdata_i, ready_i
  );
endinterface

// File: rtl/iob_wishbone_arbiter.sv
// Two-master round-robin Wishbone classic arbiter onto one IOb slave port.
// It issues one IOb transaction per grant and waits for that transaction to finish.
// A watchdog ends a hung IOb access with a Wishbone error.
// Every output comes from a register. Each output register is loaded with the
// value that the next state requires.
module iob_wishbone_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned TIMEOUT_W = 11
) (
  input logic                   clk_i,
  input logic                   arst_i,
  iob_wishbone_arbiter_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t              r_state, w_state;
  logic                r_grant, w_grant;
  logic                r_last_grant, w_last_grant;
  logic                r_abort, w_abort;
  logic [TIMEOUT_W-1:0] r_wd, w_wd;
  logic                r_valid, w_valid;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [STRB_W-1:0]   r_wstrb, w_wstrb;
  logic                r_busy, w_busy;
  logic                r_m0_ack, w_m0_ack;
  logic                r_m0_err, w_m0_err;
  logic [DATA_W-1:0]   r_m0_data, w_m0_data;
  logic                r_m1_ack, w_m1_ack;
  logic                r_m1_err, w_m1_err;
  logic [DATA_W-1:0]   r_m1_data, w_m1_data;

  logic w_m0_req, w_m1_req, w_sel, w_gnt_cyc, w_drop, w_timeout;

  // Request decode and round-robin pick (a contested grant goes to the master that lost last time)
  assign w_m0_req  = bus.m0_wb_cyc_i & bus.m0_wb_stb_i;
  assign w_m1_req  = bus.m1_wb_cyc_i & bus.m1_wb_stb_i;
  assign w_sel     = (w_m0_req & w_m1_req) ? ~r_last_grant : w_m1_req;
  // Granted master has abandoned its cycle, now or earlier in this transaction
  assign w_gnt_cyc = r_grant ? bus.m1_wb_cyc_i : bus.m0_wb_cyc_i;
  assign w_drop    = r_abort | ~w_gnt_cyc;
  assign w_timeout = (TIMEOUT != 0) && (r_wd == TIMEOUT_W'(TIMEOUT - 1));

  // State and output registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_abort      <= 1'b0;
      r_wd         <= '0;
      r_valid      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_busy       <= 1'b0;
      r_m0_ack     <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m0_data    <= '0;
      r_m1_ack     <= 1'b0;
      r_m1_err     <= 1'b0;
      r_m1_data    <= '0;
    end else begin
      r_state      <= w_state;
      r_grant      <= w_grant;
      r_last_grant <= w_last_grant;
      r_abort      <= w_abort;
      r_wd         <= w_wd;
      r_valid      <= w_valid;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_wstrb      <= w_wstrb;
      r_busy       <= w_busy;
      r_m0_ack     <= w_m0_ack;
      r_m0_err     <= w_m0_err;
      r_m0_data    <= w_m0_data;
      r_m1_ack     <= w_m1_ack;
      r_m1_err     <= w_m1_err;
      r_m1_data    <= w_m1_data;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state      = r_state;
    w_grant      = r_grant;
    w_last_grant = r_last_grant;
    w_abort      = r_abort;
    w_wd         = r_wd;
    w_valid      = 1'b0;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_wstrb      = r_wstrb;
    w_m0_ack     = 1'b0;
    w_m0_err     = 1'b0;
    w_m0_data    = r_m0_data;
    w_m1_ack     = 1'b0;
    w_m1_err     = 1'b0;
    w_m1_data    = r_m1_data;

    case (r_state)
      S_IDLE: begin
        w_abort = 1'b0;
        if (w_m0_req | w_m1_req) begin
          w_grant      = w_sel;
          w_last_grant = w_sel;
          w_addr       = w_sel ? bus.m1_wb_addr_i : bus.m0_wb_addr_i;
          w_wdata      = w_sel ? bus.m1_wb_data_i : bus.m0_wb_data_i;
          if (w_sel) w_wstrb = bus.m1_wb_we_i ? bus.m1_wb_select_i : '0;
          else       w_wstrb = bus.m0_wb_we_i ? bus.m0_wb_select_i : '0;
          w_valid      = 1'b1;
          w_state      = S_ISSUE;
        end
      end

      S_ISSUE, S_WAIT: begin
        w_abort = w_drop;
        w_wd    = (r_state == S_ISSUE) ? '0 : r_wd + TIMEOUT_W'(1);
        if (bus.ready_i) begin
          // An abandoned transfer ends silently; otherwise the granted master gets its ack
          if (w_drop) begin
            w_state = S_IDLE;
          end else begin
            w_state = S_ACK;
            if (r_grant) begin
              w_m1_ack  = 1'b1;
              w_m1_data = bus.rdata_i;
            end else begin
              w_m0_ack  = 1'b1;
              w_m0_data = bus.rdata_i;
            end
          end
        end else if (r_state == S_ISSUE) begin
          w_state = S_WAIT;
        end else if (w_timeout) begin
          if (w_drop) begin
            w_state = S_IDLE;
          end else begin
            w_state  = S_ERR;
            w_m0_err = ~r_grant;
            w_m1_err = r_grant;
          end
        end
      end

      S_ACK, S_ERR: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  // Drive the bus from the registers
  assign bus.valid_o       = r_valid;
  assign bus.address_o     = r_addr;
  assign bus.wdata_o       = r_wdata;
  assign bus.wstrb_o       = r_wstrb;
  assign bus.busy_o        = r_busy;
  assign bus.m0_wb_ack_o   = r_m0_ack;
  assign bus.m0_wb_error_o = r_m0_err;
  assign bus.m0_wb_data_o  = r_m0_data;
  assign bus.m1_wb_ack_o   = r_m1_ack;
  assign bus.m1_wb_error_o = r_m1_err;
  assign bus.m1_wb_data_o  = r_m1_data;

endmodule
